// File: rtl/video_pkg.sv
// video_pkg: shared types, constants and helpers for the video scan multiplier.
package video_pkg;

    // Replay controller states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } replay_state_t;

    // Supported line multiplication factors
    localparam int LINE_MULT_X2 = 2;
    localparam int LINE_MULT_X4 = 4;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    // Legal when LINE_MULT is 2 or 4 and the source pixel period splits evenly
    function automatic bit scanmult_cfg_legal(input int line_mult, input int pix_div);
        return ((line_mult == LINE_MULT_X2) || (line_mult == LINE_MULT_X4)) &&
               (pix_div >= line_mult) && ((pix_div % line_mult) == 0);
    endfunction

endpackage

// File: rtl/scanmult_linebuf.sv
// scanmult_linebuf: ping-pong line buffer, 2*MAX_PIX x PIX_W simple dual-port RAM.
// Address MSB selects the bank. Synchronous write, registered read (1 clk latency).
module scanmult_linebuf
    import video_pkg::*;
#(
    parameter int PIX_W   = 4,
    parameter int MAX_PIX = 1024
) (
    input  logic                            clk,
    input  logic                            wr_en,
    input  logic [clog2(MAX_PIX):0]         wr_addr,
    input  logic [PIX_W-1:0]                wr_data,
    input  logic [clog2(MAX_PIX):0]         rd_addr,
    output logic [PIX_W-1:0]                rd_data
);

    localparam int ADDR_W = clog2(MAX_PIX) + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [PIX_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/video_scan_multiplier.sv
// video_scan_multiplier: captures one source scanline and replays it LINE_MULT
// times at LINE_MULT times the source line rate, with its own hsync/line pulses.
// Optional build macro: SCANMULT_SCANLINE_EN -- reps k>=1 output pixel>>1.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | after reset, no line seen yet; outputs held at 0
// ST_REPLAY | replaying read bank, rep index in `rep`; `done` blanks after
//           | the last rep until the next line_reset
module video_scan_multiplier
    import video_pkg::*;
#(
    parameter int PIX_W     = 4,
    parameter int MAX_PIX   = 1024,
    parameter int LINE_MULT = 2,
    parameter int PIX_DIV   = 8,
    parameter int HSYNC_W   = 16,
    parameter int PER_W     = 12
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] video_in,
    input  logic             line_reset,
    output logic [PIX_W-1:0] out_video,
    output logic             out_hsync,
    output logic             out_line,
    output logic             overflow
);

    localparam int PTR_AB = clog2(MAX_PIX);
    localparam int PTR_W  = PTR_AB + 1;
    localparam int STEP   = PIX_DIV / LINE_MULT;
    localparam int SUB_W  = (clog2(STEP) > 0) ? clog2(STEP) : 1;
    localparam int REP_W  = (clog2(LINE_MULT) > 0) ? clog2(LINE_MULT) : 1;
    localparam int LM_SH  = clog2(LINE_MULT);
    localparam int HS_W   = (clog2(HSYNC_W) > 0) ? clog2(HSYNC_W) : 1;

    localparam logic [PTR_W-1:0] MAX_PTR  = PTR_W'(MAX_PIX);
    localparam logic [PER_W-1:0] PER_MAX  = {PER_W{1'b1}};
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(LINE_MULT - 1);
    localparam logic [HS_W-1:0]  HS_LOAD  = HS_W'(HSYNC_W - 1);

    generate
        if (!scanmult_cfg_legal(LINE_MULT, PIX_DIV)) begin : g_bad_mult
            $error("video_scan_multiplier: LINE_MULT must be 2 or 4 and divide PIX_DIV");
        end
        if (HSYNC_W < 1) begin : g_bad_hsync
            $error("video_scan_multiplier: HSYNC_W must be at least 1");
        end
        if (MAX_PIX < 2) begin : g_bad_maxpix
            $error("video_scan_multiplier: MAX_PIX must be at least 2");
        end
    endgenerate

    // Write side
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_bank;
    logic [PTR_W-1:0] len;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] line_period;
    logic             seen_line;

    // Replay FSM and read side
    replay_state_t    state, state_nxt;
    logic [REP_W-1:0] rep, rep_nxt;
    logic             done, done_nxt;
    logic [PER_W-1:0] rep_cnt;
    logic [PER_W-1:0] q_len;
    logic [PTR_W-1:0] rd_ptr;
    logic [SUB_W-1:0] sub_cnt;
    logic             rep_end, rep_adv, rep_fin, rep_start;

    logic [PTR_W-1:0] slot_ptr;
    logic [SUB_W-1:0] slot_sub;
    logic [PTR_W-1:0] slot_len;
    logic             slot_vld;
    logic             slot_dim;
    logic             rd_bank;

    // RAM ports and output pipeline
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [PTR_W-1:0] rd_addr;
    logic [PIX_W-1:0] rd_data;
    logic             s1_vld;
    logic             s1_dim;
    logic [HS_W-1:0]  hs_rem;

    // A pixel coinciding with line_reset lands at address 0 of the new bank
    always_comb begin
        wr_en   = pix_valid && (line_reset || (wr_ptr < MAX_PTR));
        wr_addr = line_reset ? {~wr_bank, {PTR_AB{1'b0}}}
                             : {wr_bank, wr_ptr[PTR_AB-1:0]};
    end

    // Write pointer, bank swap, line length/period capture and overflow
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr      <= '0;
            wr_bank     <= 1'b0;
            len         <= '0;
            per_cnt     <= '0;
            line_period <= '0;
            seen_line   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (line_reset) per_cnt <= PER_W'(1);
            else if (per_cnt != PER_MAX) per_cnt <= per_cnt + PER_W'(1);

            if (line_reset) begin
                len         <= wr_ptr;
                line_period <= seen_line ? per_cnt : '0;
                seen_line   <= 1'b1;
                wr_bank     <= ~wr_bank;
                wr_ptr      <= pix_valid ? PTR_W'(1) : '0;
            end else if (pix_valid) begin
                if (wr_ptr == MAX_PTR) overflow <= 1'b1;
                else wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    assign q_len = line_period >> LM_SH;

    // FSM state register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_IDLE;
            rep   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            rep   <= rep_nxt;
            done  <= done_nxt;
        end
    end

    // FSM next state: line_reset always wins over rep advance/finish
    always_comb begin
        rep_end   = (state == ST_REPLAY) && !done && (q_len != '0) && (rep_cnt == q_len);
        rep_adv   = rep_end && (rep != REP_LAST) && !line_reset;
        rep_fin   = rep_end && (rep == REP_LAST) && !line_reset;
        rep_start = line_reset || rep_adv;
        state_nxt = state;
        rep_nxt   = rep;
        done_nxt  = done;
        if (line_reset) begin
            state_nxt = ST_REPLAY;
            rep_nxt   = '0;
            done_nxt  = 1'b0;
        end else if (rep_adv) begin
            rep_nxt   = rep + REP_W'(1);
        end else if (rep_fin) begin
            done_nxt  = 1'b1;
        end
    end

    // FSM outputs: the read slot issued this cycle; a rep start reads address 0 at once
    always_comb begin
        slot_ptr = rep_start ? '0 : rd_ptr;
        slot_sub = rep_start ? '0 : sub_cnt;
        slot_len = line_reset ? wr_ptr : len;
        rd_bank  = line_reset ? wr_bank : ~wr_bank;
        rd_addr  = {rd_bank, slot_ptr[PTR_AB-1:0]};
        slot_vld = (state_nxt == ST_REPLAY) && !done_nxt && (slot_ptr < slot_len);
`ifdef SCANMULT_SCANLINE_EN
        slot_dim = (rep_nxt != '0);
`else
        slot_dim = 1'b0;
`endif
    end

    // Rep length counter and read pointer pacing
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rep_cnt <= '0;
            rd_ptr  <= '0;
            sub_cnt <= '0;
        end else begin
            if (rep_start) rep_cnt <= PER_W'(1);
            else if (rep_cnt != PER_MAX) rep_cnt <= rep_cnt + PER_W'(1);

            if (slot_sub == SUB_LAST) begin
                sub_cnt <= '0;
                rd_ptr  <= (slot_ptr == MAX_PTR) ? slot_ptr : slot_ptr + PTR_W'(1);
            end else begin
                sub_cnt <= slot_sub + SUB_W'(1);
                rd_ptr  <= slot_ptr;
            end
        end
    end

    scanmult_linebuf #(
        .PIX_W   (PIX_W),
        .MAX_PIX (MAX_PIX)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (video_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Output registers; hsync reloads to full width on every rep start
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_vld    <= 1'b0;
            s1_dim    <= 1'b0;
            out_video <= '0;
            out_line  <= 1'b0;
            out_hsync <= 1'b0;
            hs_rem    <= '0;
        end else begin
            s1_vld    <= slot_vld;
            s1_dim    <= slot_dim;
            out_video <= s1_vld ? (s1_dim ? (rd_data >> 1) : rd_data) : '0;
            out_line  <= rep_start;
            if (rep_start) begin
                out_hsync <= 1'b1;
                hs_rem    <= HS_LOAD;
            end else if (hs_rem != '0) begin
                out_hsync <= 1'b1;
                hs_rem    <= hs_rem - HS_W'(1);
            end else begin
                out_hsync <= 1'b0;
            end
        end
    end

endmodule

// File: doc/video_scan_multiplier.md
# video_scan_multiplier

Parametrised line multiplier that replaces the fixed two-times scandoubler of the video adapters. It captures one source scanline of PIX_W-bit pixels into a ping-pong line buffer. It then replays that line LINE_MULT times, each replay running at LINE_MULT times the source line rate, and generates its own output hsync and line pulses. It sits between the pixel pusher and the video output pins, and serves CGA, MDA and future modes through parameters alone.

## Interface
Parameters:
- PIX_W, 4: bits per pixel.
- MAX_PIX, 1024: maximum stored pixels per source line.
- LINE_MULT, 2: output lines per source line. Legal values are 2 or 4 (power of two).
- PIX_DIV, 8: clk cycles per source pixel. Must be divisible by LINE_MULT.
- HSYNC_W, 16: output hsync width in clk cycles. Must be ≥1.
- PER_W, 12: width of the line-period counter.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  reset; asynchronous, active-low.
- pix_valid  in  1  one-cycle strobe; video_in holds a valid source pixel.
- video_in  in  PIX_W  source pixel.
- line_reset  in  1  one-cycle pulse marking the start of a source line.
- out_video  out  PIX_W  multiplied pixel stream, registered.
- out_hsync  out  1  output hsync, high for HSYNC_W clks at the start of each output line.
- out_line  out  1  one-cycle pulse at the start of each output line.
- overflow  out  1  sticky flag: a source line exceeded MAX_PIX. Cleared only by reset.

## Operation
- Write side:
  - Each pix_valid writes video_in to the write bank at wr_ptr, then wr_ptr increments.
  - wr_ptr saturates at MAX_PIX. A write attempted at saturation is dropped and sets overflow.
- Line swap on a sampled line_reset:
  - len is latched as wr_ptr.
  - P is latched as the clk count since the previous line_reset, saturating at 2^PER_W−1.
  - Banks swap and wr_ptr clears.
- Simultaneous pix_valid and line_reset: the pixel goes to address 0 of the new line and is not counted in the latched len.
- Replay period: an output line lasts Q = P >> log2(LINE_MULT) clks. The read pointer advances every PIX_DIV/LINE_MULT clks.
- Replay states:
  - IDLE: entered on reset. out_video=0. No out_line or out_hsync pulses. Moves to REPLAY(0) on the first line_reset.
  - REPLAY(k): replays the read bank. Pixel rd_ptr is output while rd_ptr < len; otherwise out_video=0. When Q clks have elapsed and k < LINE_MULT−1, go to REPLAY(k+1). After rep LINE_MULT−1 completes, hold 0 until the next line_reset.
  - Any line_reset forces REPLAY(0) with the new bank. An unfinished rep is abandoned.
- First line_reset after reset: the previous line length is unknown, so Q is taken as 0 and only rep 0 is emitted. rep 0 ends at the next line_reset.

## Timing
- Reset values: out_video=0, out_hsync=0, out_line=0, overflow=0, state IDLE, wr_ptr=0, rd_ptr=0, len=0, P=0.
- Let T be the cycle in which line_reset is sampled:
  - At T+1, out_line pulses and out_hsync rises.
  - out_hsync stays high through T+HSYNC_W.
  - The first pixel appears on out_video at T+2 (buffer read latency is 1 clk, plus the output register).
- Rep k starts at T+1+k·Q, with the same relative timing as rep 0.
- If the start of a new rep falls inside an active hsync, the hsync restarts for a full HSYNC_W.

## Configuration
- SCANMULT_SCANLINE_EN defined: reps k≥1 output pixel>>1, giving a dimmed scanline effect. Rep 0 is unchanged.
- Undefined: all reps output identical pixel values.

## Structure
- Shared package video_pkg holds:
  - the replay state enum (IDLE, REPLAY);
  - a clog2 helper;
  - the legal LINE_MULT constants, with an elaboration-time check on LINE_MULT and PIX_DIV.
- Sub-module scanmult_linebuf is a simple dual-port RAM of 2·MAX_PIX × PIX_W.
  - Write port is synchronous.
  - Read port is registered, with 1-clk latency.
  - The bank-select bit is the RAM address MSB.

## Test plan
All scenarios use PIX_W=4, MAX_PIX=16, LINE_MULT=2, PIX_DIV=4, HSYNC_W=3.
- Reset, with no line_reset applied for 100 clks: all outputs stay 0 and no out_line pulse occurs.
- Line 1 carries pixels 1..8, one every 4 clks. Line 2 follows at P=40.
  - Expected: out_line pulses at T+1 and T+21.
  - Each rep shows 1,1,2,2,…,8,8 starting at T+2, then 0.
  - out_hsync is high for 3 clks at each rep start.
- 20 pixels in one line: overflow becomes 1 and stays 1. Replay shows exactly 16 pixels.
- line_reset arrives 30 clks into a P=40 period (during rep 1): rep 1 is abandoned, and out_line plus REPLAY(0) of the new line occur at +1.
- pix_valid coincides with line_reset while video_in=0xA: on the next line, rep 0 begins with 0xA, and the previous len excludes that pixel.
- SCANMULT_SCANLINE_EN defined, pixel value 0xE: rep 0 outputs 0xE and rep 1 outputs 0x7.
